pipeline_hazard_ctrl: RTL

Central pipeline sequencer for the 5-stage MIPS datapath. It owns the enable, write and flush controls of the PC and of the IF/ID, ID/EX and EX/MEM pipeline latches. It inserts load-use stall bubbles, squashes wrong-path instructions on a taken branch or jump, and runs a run/step/halt state machine driven by the debug unit. A HALT opcode in ID drains the pipe before the core freezes.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encoding, HALT opcode
// and drain length.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } ctrl_state_t;

    localparam logic [5:0] HALT_OP      = 6'b111111;
    localparam int         DRAIN_CYCLES = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard check between the load in EX and the
// instruction waiting in ID.
module load_use_detect #(
    parameter int W = 5
) (
    input  logic         idex_mem_read,
    input  logic [W-1:0] idex_rt,
    input  logic [W-1:0] ifid_rs,
    input  logic [W-1:0] ifid_rt,
    input  logic         ifid_uses_rt,
    output logic         load_use
);

    logic [W-1:0] rs_bit_eq;
    logic [W-1:0] rt_bit_eq;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_cmp
            assign rs_bit_eq[gi] = ~(idex_rt[gi] ^ ifid_rs[gi]);
            assign rt_bit_eq[gi] = ~(idex_rt[gi] ^ ifid_rt[gi]);
        end
    endgenerate

    // Register 0 is hardwired to zero, so a load into it never creates a hazard.
    assign load_use = idex_mem_read & (|idex_rt) &
                      ((&rs_bit_eq) | (ifid_uses_rt & (&rt_bit_eq)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: run/step/halt FSM, HALT drain,
// load-use stall and branch squash control of PC and pipeline latches.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int W     = 5,
    parameter int CNT_B = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_cmd,
    input  logic             step_cmd,
    input  logic             halt_cmd,
    input  logic [5:0]       ifid_opcode,
    input  logic [W-1:0]     ifid_rs,
    input  logic [W-1:0]     ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_mem_read,
    input  logic [W-1:0]     idex_rt,
    input  logic             mem_pc_src,
    output logic             pipe_en,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic             paused,
    output logic [CNT_B-1:0] cycle_cnt
);

    ctrl_state_t      state_reg, state_next;
    logic [1:0]       drain_cnt_reg, drain_cnt_next;
    logic [CNT_B-1:0] cycle_cnt_reg;

    logic load_use;
    logic flush;
    logic halt_det;

    load_use_detect #(.W(W)) u_load_use_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .ifid_uses_rt  (ifid_uses_rt),
        .load_use      (load_use)
    );

    assign flush    = mem_pc_src;
    assign halt_det = ((state_reg == RUN) || (state_reg == STEP)) &&
                      (ifid_opcode == HALT_OP) && !flush;
    assign pipe_en  = (state_reg == RUN) || (state_reg == STEP) || (state_reg == DRAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= 2'd0;
            cycle_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            if (pipe_en) begin
                cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (run_cmd) begin
                    state_next = RUN;
                end else if (step_cmd) begin
                    state_next = STEP;
                end
            end
            RUN: begin
                if (halt_cmd) begin
                    state_next = IDLE;
                end else if (halt_det) begin
                    state_next     = DRAIN;
                    drain_cnt_next = 2'(DRAIN_CYCLES);
                end
            end
            STEP: begin
                if (halt_det) begin
                    state_next     = DRAIN;
                    drain_cnt_next = 2'(DRAIN_CYCLES);
                end else begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                // A taken branch means the HALT was on the wrong path.
                if (flush) begin
                    state_next     = RUN;
                    drain_cnt_next = 2'd0;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 2'd1;
                    if (drain_cnt_reg <= 2'd1) begin
                        state_next     = HALTED;
                        drain_cnt_next = 2'd0;
                    end
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next     = IDLE;
                drain_cnt_next = 2'd0;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (pipe_en) begin
            if (flush) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (load_use) begin
                idex_flush = 1'b1;
            end else if (halt_det || (state_reg == DRAIN)) begin
                // Let the HALT move on to EX while bubbles fill in behind it.
                ifid_write = 1'b1;
                ifid_flush = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end
    end

    assign halted    = (state_reg == HALTED);
    assign paused    = (state_reg == IDLE);
    assign cycle_cnt = cycle_cnt_reg;

endmodule
